// File: rtl/sram_lane_ctrl_if.sv
// sram_lane_ctrl_if: request/response handshake between the cache FSM and the lane controller
interface sram_lane_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_wen;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [3:0]            req_be;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata
   );
   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_lane_ctrl.sv
// sram_lane_ctrl: rotates one 32-bit request at any byte offset across four 8-bit SRAM cells
module sram_lane_ctrl #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int SRAM_ADDR_WIDTH = 16,
   parameter int SRAM_LATENCY    = 7
) (
   input  logic                       clk,
   input  logic                       rst,
   sram_lane_ctrl_if.slave            bus,
   input  logic [7:0]                 cell_0_dout,
   input  logic [7:0]                 cell_1_dout,
   input  logic [7:0]                 cell_2_dout,
   input  logic [7:0]                 cell_3_dout,
   output logic [7:0]                 cell_0_din,
   output logic [7:0]                 cell_1_din,
   output logic [7:0]                 cell_2_din,
   output logic [7:0]                 cell_3_din,
   output logic [SRAM_ADDR_WIDTH-1:0] cell_0_addr,
   output logic [SRAM_ADDR_WIDTH-1:0] cell_1_addr,
   output logic [SRAM_ADDR_WIDTH-1:0] cell_2_addr,
   output logic [SRAM_ADDR_WIDTH-1:0] cell_3_addr,
   output logic                       cell_0_sense_en,
   output logic                       cell_1_sense_en,
   output logic                       cell_2_sense_en,
   output logic                       cell_3_sense_en,
   output logic                       cell_0_wen,
   output logic                       cell_1_wen,
   output logic                       cell_2_wen,
   output logic                       cell_3_wen
);
   localparam int CW = $clog2(SRAM_LATENCY + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   if (SRAM_LATENCY < 1) begin : g_lat_check
      $error("SRAM_LATENCY must be at least 1");
   end
   state_t                     state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       wen_q, wen_d;
   logic [1:0]                 off_q, off_d;
   logic [3:0]                 be_q, be_d;
   logic [SRAM_ADDR_WIDTH-1:0] addr_q [4];
   logic [SRAM_ADDR_WIDTH-1:0] addr_d [4];
   logic [7:0]                 din_q [4];
   logic [7:0]                 din_d [4];
   logic [3:0]                 cwen_q, cwen_d, csen_q, csen_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
   logic [SRAM_ADDR_WIDTH-1:0] w;
   logic [1:0]                 s;
   logic [1:0]                 byte_of [4];
   logic [1:0]                 lane_of [4];
   logic [7:0]                 dout [4];
   logic                       accept;
   logic                       unused;
   assign w      = bus.req_addr[SRAM_ADDR_WIDTH+1:2];
   assign s      = bus.req_addr[1:0];
   assign dout   = '{cell_0_dout, cell_1_dout, cell_2_dout, cell_3_dout};
   assign accept = bus.req_valid & (state_q == IDLE);
   assign unused = ^bus.req_addr[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2];
   // byte_of: which request byte lands on a lane; lane_of: which lane feeds a response byte
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         byte_of[i] = 2'(i) - s;
         lane_of[i] = 2'(i) + off_q;
      end
   end
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wen_d       = wen_q;
      off_d       = off_q;
      be_d        = be_q;
      addr_d      = addr_q;
      din_d       = din_q;
      cwen_d      = '0;
      csen_d      = '0;
      rsp_valid_d = 1'b0;
      rdata_d     = rdata_q;
      unique case (state_q)
         IDLE: if (accept) begin
            state_d = ISSUE;
            wen_d   = bus.req_wen;
            off_d   = s;
            be_d    = bus.req_be;
            for (int i = 0; i < 4; i++) begin
               addr_d[i] = (2'(i) < s) ? w + 1'b1 : w;
               din_d[i]  = bus.req_be[byte_of[i]] ? bus.req_wdata[8*byte_of[i] +: 8] : 8'h00;
               cwen_d[i] = bus.req_be[byte_of[i]] & bus.req_wen;
               csen_d[i] = bus.req_be[byte_of[i]] & ~bus.req_wen;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(SRAM_LATENCY - 1)) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               for (int i = 0; i < 4; i++)
                  rdata_d[8*i +: 8] = (be_q[i] & ~wen_q) ? dout[lane_of[i]] : 8'h00;
            end
         end
         RESP: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wen_q       <= 1'b0;
         off_q       <= '0;
         be_q        <= '0;
         addr_q      <= '{default: '0};
         din_q       <= '{default: '0};
         cwen_q      <= '0;
         csen_q      <= '0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wen_q       <= wen_d;
         off_q       <= off_d;
         be_q        <= be_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         cwen_q      <= cwen_d;
         csen_q      <= csen_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
      end
   end
   assign bus.req_ready   = (state_q == IDLE) & rst;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rdata_q;
   assign cell_0_addr     = addr_q[0];
   assign cell_1_addr     = addr_q[1];
   assign cell_2_addr     = addr_q[2];
   assign cell_3_addr     = addr_q[3];
   assign cell_0_din      = din_q[0];
   assign cell_1_din      = din_q[1];
   assign cell_2_din      = din_q[2];
   assign cell_3_din      = din_q[3];
   assign cell_0_wen      = cwen_q[0];
   assign cell_1_wen      = cwen_q[1];
   assign cell_2_wen      = cwen_q[2];
   assign cell_3_wen      = cwen_q[3];
   assign cell_0_sense_en = csen_q[0];
   assign cell_1_sense_en = csen_q[1];
   assign cell_2_sense_en = csen_q[2];
   assign cell_3_sense_en = csen_q[3];
endmodule

// File: tb/tb_sram_lane_ctrl.sv
// tb_sram_lane_ctrl: randomized requests scored against a byte-addressed reference memory
module tb_sram_lane_ctrl;
   localparam int L   = 7;
   localparam int SAW = 16;
   localparam int MW  = 1 << (SAW + 2);
   typedef struct packed {
      logic [31:0]          t;
      logic [31:0]          rdata;
      logic                 w;
      logic [3:0]           mask;
      logic [3:0][SAW-1:0]  a;
      logic [3:0][7:0]      d;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];
   logic [7:0] ref_mem [int];
   logic [7:0] cmem [int];
   logic [7:0] dout [4];
   logic [7:0] din [4];
   logic [7:0] pdata [4];
   logic [SAW-1:0] caddr [4];
   logic [3:0] cwen, csen;
   logic pend [4];
   int pcnt [4];
   sram_lane_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
   sram_lane_ctrl #(.SRAM_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .cell_0_dout(dout[0]), .cell_1_dout(dout[1]), .cell_2_dout(dout[2]), .cell_3_dout(dout[3]),
      .cell_0_din(din[0]), .cell_1_din(din[1]), .cell_2_din(din[2]), .cell_3_din(din[3]),
      .cell_0_addr(caddr[0]), .cell_1_addr(caddr[1]), .cell_2_addr(caddr[2]), .cell_3_addr(caddr[3]),
      .cell_0_sense_en(csen[0]), .cell_1_sense_en(csen[1]), .cell_2_sense_en(csen[2]), .cell_3_sense_en(csen[3]),
      .cell_0_wen(cwen[0]), .cell_1_wen(cwen[1]), .cell_2_wen(cwen[2]), .cell_3_wen(cwen[3])
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic int ck(input int l, input logic [SAW-1:0] ad);
      return l * (1 << SAW) + int'(ad);
   endfunction
   // Cell model: read data is valid only in the single cycle SRAM_LATENCY cycles after the strobe
   for (genvar g = 0; g < 4; g++) begin : g_cell
      assign dout[g] = (pend[g] && pcnt[g] == 0) ? pdata[g] : ~pdata[g];
   end
   always @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (cwen[l]) cmem[ck(l, caddr[l])] = din[l];
         if (!rst) pend[l] <= 1'b0;
         else if (csen[l]) begin
            pend[l]  <= 1'b1;
            pcnt[l]  <= L - 1;
            pdata[l] <= cmem.exists(ck(l, caddr[l])) ? cmem[ck(l, caddr[l])] : 8'h00;
         end else if (pend[l] && pcnt[l] == 0) pend[l] <= 1'b0;
         else if (pend[l]) pcnt[l] <= pcnt[l] - 1;
      end
   end
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic send(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       output int t_acc);
      exp_t e;
      int n, b;
      bus.req_valid = 1'b1;
      bus.req_wen   = w;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      bus.req_be    = be;
      n = 0;
      while (!bus.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      t_acc = cyc;
      if (!bus.req_ready) begin
         chk("accept_timeout", bus.req_ready, 1'b1);
         bus.req_valid = 1'b0;
         return;
      end
      e   = '0;
      e.t = cyc;
      e.w = w;
      for (int k = 0; k < 4; k++) begin
         b = (int'(a[SAW+1:0]) + k) % MW;
         e.a[b % 4] = SAW'(b / 4);
         e.d[b % 4] = be[k] ? wd[8*k +: 8] : 8'h00;
         if (be[k]) begin
            e.mask[b % 4] = 1'b1;
            if (w) ref_mem[b] = wd[8*k +: 8];
            else e.rdata[8*k +: 8] = ref_mem.exists(b) ? ref_mem[b] : 8'h00;
         end
      end
      exp_q.push_back(e);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() > 0 && n < 4 * L + 20) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         chk("idle_timeout", 64'(exp_q.size()), 0);
         exp_q.delete();
      end
   endtask
   always @(negedge clk) begin
      if (rst) begin
         if (exp_q.size() > 0 && cyc == int'(exp_q[0].t) + 1) begin
            chk("strobes", {cwen, csen},
                {exp_q[0].w ? exp_q[0].mask : 4'h0, exp_q[0].w ? 4'h0 : exp_q[0].mask});
            for (int l = 0; l < 4; l++) begin
               chk($sformatf("cell_%0d_addr", l), caddr[l], exp_q[0].a[l]);
               if (exp_q[0].w) chk($sformatf("cell_%0d_din", l), din[l], exp_q[0].d[l]);
            end
         end else if (|{cwen, csen}) chk("stray_strobe", {cwen, csen}, 8'h00);
         if (bus.rsp_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rsp", bus.rsp_valid, 1'b0);
            else begin
               chk("rsp_latency", 64'(cyc - int'(exp_q[0].t)), L + 2);
               chk("rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
               void'(exp_q.pop_front());
            end
         end else if (exp_q.size() > 0 && cyc > int'(exp_q[0].t) + L + 2) begin
            chk("rsp_timeout", bus.rsp_valid, 1'b1);
            void'(exp_q.pop_front());
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int t1, t2;
      logic [31:0] a;
      bus.req_valid = 1'b0;
      bus.req_wen   = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 1'b0);
      chk("rst_rsp", {bus.rsp_valid, bus.rsp_rdata}, 0);
      chk("rst_strobes", {cwen, csen}, 0);
      chk("rst_addr", {caddr[0], caddr[1], caddr[2], caddr[3]}, 0);
      chk("rst_din", {din[0], din[1], din[2], din[3]}, 0);
      rst = 1'b1;
      #1 chk("ready_after_rst", bus.req_ready, 1'b1);
      @(negedge clk);
      send(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, t1); wait_idle();
      send(1'b1, 32'h103, 32'h33221144, 4'hF, t1); wait_idle();
      send(1'b0, 32'h103, 32'h0, 4'hF, t1); wait_idle();
      send(1'b1, 32'h3FFFE, 32'h0BADF00D, 4'hF, t1); wait_idle();
      send(1'b0, 32'hFFC3FFFE, 32'h0, 4'hF, t1); wait_idle();
      send(1'b1, 32'h101, 32'h0000A55A, 4'h3, t1); wait_idle();
      send(1'b0, 32'h100, 32'h0, 4'hF, t1); wait_idle();
      send(1'b0, 32'h102, 32'h0, 4'h0, t1); wait_idle();
      send(1'b1, 32'h200, 32'h01234567, 4'hF, t1);
      bus.req_valid = 1'b1;
      bus.req_wen   = 1'b0;
      bus.req_addr  = 32'h201;
      bus.req_be    = 4'hF;
      for (int i = 0; i < L + 2; i++) begin
         chk("ready_busy", bus.req_ready, 1'b0);
         @(negedge clk);
      end
      send(1'b0, 32'h201, 32'h0, 4'hF, t2);
      chk("b2b_accept", 64'(t2 - t1), L + 3);
      wait_idle();
      for (int i = 0; i < 200; i++) begin
         a = $urandom;
         a[SAW+1:0] = $urandom_range(0, 1) ? 18'h3FFF0 + 18'($urandom_range(0, 15))
                                           : 18'h00100 + 18'($urandom_range(0, 31));
         send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), t1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle();
      send(1'b1, 32'h3FFFD, 32'hCAFEF00D, 4'hF, t1);
      while (cyc < t1 + 4) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_strobes", {cwen, csen}, 0);
      chk("midrst_rsp", bus.rsp_valid, 1'b0);
      chk("midrst_ready", bus.req_ready, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("midrst_ready_after", bus.req_ready, 1'b1);
      repeat (L + 5) @(negedge clk);
      send(1'b0, 32'h3FFFD, 32'h0, 4'hF, t1); wait_idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
